// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader
// Description : Writer side of the instruction-memory initialization port of
//               the instruction fetch stage. Assembles 32-bit instruction
//               words (MSB first) from the byte stream delivered by the debug
//               UART receiver and writes them to consecutive word addresses,
//               holding the CPU halted while a load session is in progress.
//               A session ends when HALT_WORD has been written or when the
//               last word of the memory has been written.
//
// Ports       :
//   clk          - system clock
//   i_rst_n      - asynchronous active-low reset
//   i_start      - one-cycle pulse starting a load session (IDLE/DONE only)
//   i_rx_valid   - one-cycle strobe, i_rx_data holds a new byte
//   i_rx_data    - received byte
//   o_we         - instruction memory write enable (high only in WRITE)
//   o_instr_data - word being written
//   o_inst_addr  - byte address of the word being written
//   o_halt       - CPU halt request, equal to o_busy
//   o_busy       - high while receiving or writing
//   o_done       - high once the session has finished
//   o_full       - session ended on capacity rather than on HALT_WORD
//   o_word_count - words written in the current/last session
//
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
    parameter int          NB_ADDR   = 8,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_rx_valid,
    input  logic [7:0]         i_rx_data,
    output logic               o_we,
    output logic [31:0]        o_instr_data,
    output logic [31:0]        o_inst_addr,
    output logic               o_halt,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_full,
    output logic [NB_ADDR-2:0] o_word_count
);

    // Address of the last word in memory (stride of 4 bytes).
    localparam logic [NB_ADDR-1:0] LAST_ADDR   = {{(NB_ADDR-2){1'b1}}, 2'b00};
    localparam logic [NB_ADDR-1:0] ADDR_STRIDE = NB_ADDR'(4);
    localparam logic [NB_ADDR-2:0] ONE_WORD    = (NB_ADDR-1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;

    // Only the three most recent bytes are kept: the fourth byte goes
    // straight from i_rx_data into the assembled word.
    logic [23:0]          shift;
    logic [1:0]           byte_cnt;
    logic [NB_ADDR-1:0]   addr;       // address of the next word to write
    logic [NB_ADDR-1:0]   wr_addr;    // address presented on o_inst_addr
    logic [31:0]          instr_data;
    logic [NB_ADDR-2:0]   word_count;
    logic                 full;

    logic                 session_start;
    logic                 accept_byte;
    logic                 word_complete;

    // A new session may only begin when no session is in progress.
    assign session_start = i_start && ((state == IDLE) || (state == DONE));

    // Bytes are taken in WRITE too, so a strobe arriving in the write cycle
    // becomes byte 1 of the next word and back-to-back strobes are lossless.
    assign accept_byte   = i_rx_valid && ((state == RECV) || (state == WRITE));

    // Only RECV can complete a word: on entry to WRITE the byte counter has
    // just wrapped to 0, so at most byte 1 of the next word lands in WRITE.
    assign word_complete = i_rx_valid && (state == RECV) && (byte_cnt == 2'd3);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                if (word_complete) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                // HALT_WORD takes priority over the capacity condition.
                if (instr_data == HALT_WORD) begin
                    state_next = DONE;
                end else if (addr == LAST_ADDR) begin
                    state_next = DONE;
                end else begin
                    state_next = RECV;
                end
            end
            DONE: begin
                if (i_start) begin
                    state_next = RECV;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: byte assembly, address and session bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift      <= '0;
            byte_cnt   <= '0;
            addr       <= '0;
            wr_addr    <= '0;
            instr_data <= '0;
            word_count <= '0;
            full       <= 1'b0;
        end else if (session_start) begin
            shift      <= '0;
            byte_cnt   <= '0;
            addr       <= '0;
            word_count <= '0;
            full       <= 1'b0;
        end else begin
            if (accept_byte) begin
                shift    <= {shift[15:0], i_rx_data};
                byte_cnt <= byte_cnt + 2'd1;
            end

            // Output word and address are loaded together on entry to WRITE
            // and then held until the next word is complete.
            if (word_complete) begin
                instr_data <= {shift, i_rx_data};
                wr_addr    <= addr;
            end

            if (state == WRITE) begin
                word_count <= word_count + ONE_WORD;
                addr       <= addr + ADDR_STRIDE;
                if ((instr_data != HALT_WORD) && (addr == LAST_ADDR)) begin
                    full <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_we         = (state == WRITE);
    assign o_busy       = (state == RECV) || (state == WRITE);
    assign o_halt       = o_busy;
    assign o_done       = (state == DONE);
    assign o_full       = full;
    assign o_word_count = word_count;
    assign o_instr_data = instr_data;
    assign o_inst_addr  = {{(32-NB_ADDR){1'b0}}, wr_addr};

endmodule
`default_nettype wire
